// File: rtl/seg_display_mux.sv
`default_nettype none
// ============================================================================
// Module   : seg_display_mux
// Purpose  : Time-multiplexed 4-digit seven-segment driver. Captures the four
//            BCD digits once per scan frame, decodes them to active-low
//            segments, and drives one active-low anode per slot with optional
//            per-digit blinking for adjust mode.
// Revision : 1.0 - initial release
// ============================================================================
module seg_display_mux #(
  parameter int unsigned REFRESH_DIV = 100000,   // clock cycles per digit slot
  parameter int unsigned BLINK_DIV   = 25000000  // clock cycles per blink phase
) (
  input  logic       clk_100mhz,
  input  logic       rst,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic [3:0] digit3,
  input  logic       blink_en,
  input  logic [3:0] blink_mask,
  output logic       CA,
  output logic       CB,
  output logic       CC,
  output logic       CD,
  output logic       CE,
  output logic       CF,
  output logic       CG,
  output logic       AN0,
  output logic       AN1,
  output logic       AN2,
  output logic       AN3
);

  localparam int unsigned c_refresh_w = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned c_blink_w   = (BLINK_DIV > 1)   ? $clog2(BLINK_DIV)   : 1;
  localparam logic [c_refresh_w-1:0] c_refresh_last = c_refresh_w'(REFRESH_DIV - 1);
  localparam logic [c_blink_w-1:0]   c_blink_last   = c_blink_w'(BLINK_DIV - 1);

  logic [c_refresh_w-1:0] refresh_cnt_q, refresh_cnt_d;
  logic [1:0]             scan_idx_q, scan_idx_d;
  logic [c_blink_w-1:0]   blink_cnt_q, blink_cnt_d;
  logic                   blink_phase_q, blink_phase_d;
  logic [3:0]             shadow_q [4];
  logic [3:0]             shadow_d [4];
  logic                   load_pending_q;
  logic [3:0]             an_q, an_d;
  logic [6:0]             seg_q, seg_d;

  logic tick;
  logic blink_wrap;
  logic capture;
  logic blank;

  // BCD to {a,b,c,d,e,f,g}, 0 = segment lit; non-BCD codes show nothing
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    case (bcd)
      4'd0:    bcd_to_seg = 7'b0000001;
      4'd1:    bcd_to_seg = 7'b1001111;
      4'd2:    bcd_to_seg = 7'b0010010;
      4'd3:    bcd_to_seg = 7'b0000110;
      4'd4:    bcd_to_seg = 7'b1001100;
      4'd5:    bcd_to_seg = 7'b0100100;
      4'd6:    bcd_to_seg = 7'b0100000;
      4'd7:    bcd_to_seg = 7'b0001111;
      4'd8:    bcd_to_seg = 7'b0000000;
      4'd9:    bcd_to_seg = 7'b0000100;
      default: bcd_to_seg = 7'b1111111;
    endcase
  endfunction

  // Slot timing, scan position, free-running blink phase and frame capture
  always_comb begin
    tick          = (refresh_cnt_q == c_refresh_last);
    blink_wrap    = (blink_cnt_q == c_blink_last);
    refresh_cnt_d = tick ? '0 : refresh_cnt_q + 1'b1;
    scan_idx_d    = tick ? scan_idx_q + 2'd1 : scan_idx_q;
    blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + 1'b1;
    blink_phase_d = blink_wrap ? ~blink_phase_q : blink_phase_q;
    // Digits are only sampled at the end of the last slot of a frame (or right
    // after reset) so a frame never mixes old and new values.
    capture       = (tick && (scan_idx_q == 2'd3)) || load_pending_q;
    shadow_d[0]   = capture ? digit0 : shadow_q[0];
    shadow_d[1]   = capture ? digit1 : shadow_q[1];
    shadow_d[2]   = capture ? digit2 : shadow_q[2];
    shadow_d[3]   = capture ? digit3 : shadow_q[3];
  end

  // Next output pattern: one anode for the current slot unless that digit blinks off
  always_comb begin
    an_d  = 4'hF;
    blank = blink_en & blink_mask[scan_idx_q] & blink_phase_q;
    if (!blank) begin
      an_d[scan_idx_q] = 1'b0;
    end
    seg_d = bcd_to_seg(shadow_q[scan_idx_q]);
  end

  // State and output registers; reset darkens the display immediately
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      refresh_cnt_q  <= '0;
      scan_idx_q     <= 2'd0;
      blink_cnt_q    <= '0;
      blink_phase_q  <= 1'b0;
      shadow_q[0]    <= 4'd0;
      shadow_q[1]    <= 4'd0;
      shadow_q[2]    <= 4'd0;
      shadow_q[3]    <= 4'd0;
      load_pending_q <= 1'b1;
      an_q           <= 4'hF;
      seg_q          <= 7'h7F;
    end else begin
      refresh_cnt_q  <= refresh_cnt_d;
      scan_idx_q     <= scan_idx_d;
      blink_cnt_q    <= blink_cnt_d;
      blink_phase_q  <= blink_phase_d;
      shadow_q[0]    <= shadow_d[0];
      shadow_q[1]    <= shadow_d[1];
      shadow_q[2]    <= shadow_d[2];
      shadow_q[3]    <= shadow_d[3];
      load_pending_q <= 1'b0;
      an_q           <= an_d;
      seg_q          <= seg_d;
    end
  end

  assign {CA, CB, CC, CD, CE, CF, CG} = seg_q;
  assign {AN3, AN2, AN1, AN0}         = an_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_display_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_display_mux
// Purpose  : Self-checking bench for seg_display_mux with a cycle scoreboard
//            plus directed checks of scan order, capture, blink and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_display_mux;

  localparam int unsigned REFRESH_DIV = 4;
  localparam int unsigned BLINK_DIV   = 64;
  localparam int unsigned FRAME_LEN   = 4 * REFRESH_DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] d0, d1, d2, d3;
  logic       blink_en;
  logic [3:0] blink_mask;
  logic       CA, CB, CC, CD, CE, CF, CG;
  logic       AN0, AN1, AN2, AN3;

  wire [3:0] an_obs  = {AN3, AN2, AN1, AN0};
  wire [6:0] seg_obs = {CA, CB, CC, CD, CE, CF, CG};

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       chk_seg;
  } exp_t;

  exp_t        sb_q[$];
  int          tests = 0;
  int          fails = 0;
  int          mk = 0;          // edges since reset release, as seen by the model
  logic [15:0] msh = '0;        // model shadow {digit3,digit2,digit1,digit0}
  int          an_cnt[4] = '{0, 0, 0, 0};
  bit          counting = 1'b0;

  seg_display_mux #(
    .REFRESH_DIV (REFRESH_DIV),
    .BLINK_DIV   (BLINK_DIV)
  ) dut (
    .clk_100mhz (clk),
    .rst        (rst),
    .digit0     (d0),
    .digit1     (d1),
    .digit2     (d2),
    .digit3     (d3),
    .blink_en   (blink_en),
    .blink_mask (blink_mask),
    .CA (CA), .CB (CB), .CC (CC), .CD (CD), .CE (CE), .CF (CF), .CG (CG),
    .AN0 (AN0), .AN1 (AN1), .AN2 (AN2), .AN3 (AN3)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_seg(input logic [3:0] d);
    case (d)
      4'd0:    ref_seg = 7'b0000001;
      4'd1:    ref_seg = 7'b1001111;
      4'd2:    ref_seg = 7'b0010010;
      4'd3:    ref_seg = 7'b0000110;
      4'd4:    ref_seg = 7'b1001100;
      4'd5:    ref_seg = 7'b0100100;
      4'd6:    ref_seg = 7'b0100000;
      4'd7:    ref_seg = 7'b0001111;
      4'd8:    ref_seg = 7'b0000000;
      4'd9:    ref_seg = 7'b0000100;
      default: ref_seg = 7'b1111111;
    endcase
  endfunction

  // Expected outputs after the k-th edge since reset release (k >= 1)
  function automatic exp_t expect_at(input int k, input logic [15:0] sh,
                                     input logic en, input logic [3:0] mask);
    exp_t e;
    int   idx;
    bit   ph;
    idx       = ((k - 1) / REFRESH_DIV) % 4;
    ph        = (((k - 1) / BLINK_DIV) % 2) == 1;
    e.an      = 4'hF;
    if (!(en && mask[idx] && ph)) e.an[idx] = 1'b0;
    e.seg     = ref_seg(sh[idx*4 +: 4]);
    e.chk_seg = (k > 1);
    return e;
  endfunction

  // Reference model: push the expectation for each edge, track frame capture
  always @(posedge clk) begin
    if (rst) begin
      mk  <= 0;
      msh <= '0;
    end else begin
      sb_q.push_back(expect_at(mk + 1, msh, blink_en, blink_mask));
      mk <= mk + 1;
      if (mk == 0 || ((mk + 1) % FRAME_LEN) == 0) msh <= {d3, d2, d1, d0};
    end
  end

  task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and compare against the scoreboard on the falling edge
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (rst) begin
      sb_q.delete();
      chk("reset_dark", {an_obs, seg_obs}, {4'hF, 7'h7F});
    end else if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("sb_an", {7'd0, an_obs}, {7'd0, e.an});
      if (e.chk_seg) chk("sb_seg", {4'd0, seg_obs}, {4'd0, e.seg});
      if (counting) begin
        for (int i = 0; i < 4; i++) begin
          if (an_obs == ~(4'b0001 << i)) an_cnt[i]++;
        end
      end
    end
  endtask

  // Step until anode idx is the active one (bounded), then check its segments
  task automatic wait_slot(input int idx, input logic [6:0] segexp, input string tag);
    logic [3:0] pat;
    int         n;
    pat = ~(4'b0001 << idx);
    n   = 0;
    do begin
      step();
      n++;
    end while (an_obs !== pat && n < 64);
    chk({tag, "_an"}, {7'd0, an_obs}, {7'd0, pat});
    chk(tag, {4'd0, seg_obs}, {4'd0, segexp});
  endtask

  initial begin
    rst        = 1'b1;
    d0 = 4'd1; d1 = 4'd2; d2 = 4'd3; d3 = 4'd4;
    blink_en   = 1'b0;
    blink_mask = 4'b0000;

    // Reset hold and scan order
    repeat (10) step();
    rst = 1'b0;
    step();
    chk("first_an0", {7'd0, an_obs}, {7'd0, 4'b1110});
    wait_slot(1, 7'b0010010, "scan_an1");
    wait_slot(2, 7'b0000110, "scan_an2");
    wait_slot(3, 7'b1001100, "scan_an3");
    wait_slot(0, 7'b1001111, "wrap_an0");

    // Frame-boundary capture
    wait_slot(2, 7'b0000110, "frame_an2");
    d0 = 4'd8;
    wait_slot(3, 7'b1001100, "frame_an3");
    wait_slot(0, 7'b0000000, "frame_an0_new");

    // Invalid BCD blanks the digit
    d1 = 4'hC;
    wait_slot(3, 7'b1001100, "inv_an3");
    wait_slot(0, 7'b0000000, "inv_an0");
    wait_slot(1, 7'b1111111, "invalid_bcd");

    // Blink digit 1 across several phases
    d0 = 4'd1; d1 = 4'd2;
    blink_en   = 1'b1;
    blink_mask = 4'b0010;
    repeat (260) step();
    blink_en   = 1'b0;
    blink_mask = 4'b0000;

    // Asynchronous reset in the middle of the AN2 slot
    wait_slot(2, 7'b0000110, "pre_reset_an2");
    #2 rst = 1'b1;
    #1 chk("async_dark", {an_obs, seg_obs}, {4'hF, 7'h7F});
    step();
    rst = 1'b0;
    step();
    chk("restart_an0", {7'd0, an_obs}, {7'd0, 4'b1110});
    step();
    chk("restart_seg", {4'd0, seg_obs}, {4'd0, 7'b1001111});

    // Long run: even duty per anode
    d0 = 4'd9; d1 = 4'd0; d2 = 4'd5; d3 = 4'd7;
    counting = 1'b1;
    repeat (1000) step();
    counting = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tests++;
      assert (an_cnt[i] >= 250 - REFRESH_DIV && an_cnt[i] <= 250 + REFRESH_DIV)
      else begin
        fails++;
        $error("FAIL duty_an%0d observed=%0d expected=250+-%0d", i, an_cnt[i], REFRESH_DIV);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg_display_mux.md
Name: seg_display_mux

Overview:
- Time-multiplexed 4-digit seven-segment driver for the stopwatch.
- Sits directly downstream of the stopwatch counter core. It takes four BCD digits plus adjust-mode blink controls, and drives the board's shared cathodes CA..CG and anodes AN0..AN3.
- Captures digits at frame boundaries so the display never tears mid-scan.
- Decodes BCD to active-low segments.

Parameters:
- REFRESH_DIV, 100000: clock cycles per digit slot (1 kHz slot rate at 100 MHz).
- BLINK_DIV, 25000000: clock cycles per blink phase toggle (2 Hz blink at 100 MHz).

Ports:
- clk_100mhz  input  1  system clock, 100 MHz.
- rst  input  1  asynchronous, active-high reset.
- digit0  input  4  BCD, rightmost digit (AN0).
- digit1  input  4  BCD, digit for AN1.
- digit2  input  4  BCD, digit for AN2.
- digit3  input  4  BCD, leftmost digit (AN3).
- blink_en  input  1  enables blinking of the masked digits (adjust mode).
- blink_mask  input  4  bit i set means digit i blinks when blink_en=1.
- CA..CG  output  1 each  segments a..g, active low, registered.
- AN0..AN3  output  1 each  digit anodes, active low, registered; exactly one is low at a time, or none while blanked or in reset.

Behaviour:
- Reset state (asynchronous, while rst=1):
  - refresh_cnt=0, scan_idx=0, blink_cnt=0, blink_phase=0.
  - Shadow digits all 0; load_pending=1.
  - All AN*=1 and all C*=1 (display dark).
- Refresh counter:
  - refresh_cnt counts 0..REFRESH_DIV-1 and wraps to 0.
  - tick=1 in the cycle refresh_cnt==REFRESH_DIV-1.
  - On tick, scan_idx increments mod 4 (3 wraps to 0).
- Shadow capture:
  - shadow[3:0] load from digit0..digit3 on any edge where (tick && scan_idx==3) or load_pending==1.
  - load_pending clears on the first clock edge after reset release.
  - Input changes at any other time must not change the displayed digits until the next frame boundary.
- Blink:
  - blink_cnt counts 0..BLINK_DIV-1; blink_phase toggles on wrap.
  - Free-running and independent of the scan.
  - blank_i = blink_en & blink_mask[i] & blink_phase.
- Output register, updated every cycle from the current scan_idx and shadow:
  - AN[scan_idx]=0 unless blank_i, in which case all AN=1. All other AN=1.
  - C* = decode(shadow[scan_idx]).
  - Latency: outputs reflect a scan_idx/shadow change one clock later.
  - First edge after reset release: AN0 goes low with decode(digit0 as sampled on that same edge).
  - Implementation: decode from the next-state shadow, or equivalently, C* valid from the second edge onward. The bench must accept C* valid by the second edge.
- Decode (CA..CG, a..g, 0=lit):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - 10..15: 1111111 (blank, no error flag).
- Boundary conditions:
  - blink_en=0: mask ignored.
  - blink_mask=1111 with phase=1: all AN high for the whole phase.
  - blink_en changing mid-slot takes effect on the next cycle; no wait for a frame boundary.
  - rst asserted mid-frame: outputs go dark immediately (asynchronous). After release, scanning restarts at AN0 with a fresh shadow load.
  - tick coinciding with a blink wrap: both take effect on the same edge.
- No combinational path from any input to any output.

Test Plan:
- Bench parameters: REFRESH_DIV=4, BLINK_DIV=64.
- Reset and scan order: rst high 10 cycles, digits=1,2,3,4 (digit0..digit3). Required: AN all 1 and C* all 1 during reset. After release: AN0 low with C*=1001111 ("1"). Slots of 4 cycles each then show AN1 "2"=0010010, AN2 "3"=0000110, AN3 "4"=1001100, then wrap to AN0. Never two anodes low at once.
- Frame-boundary capture: change digit0 from 1 to 8 while AN2 is active. Required: AN0 still shows 1001111 until the AN3 slot ends, and the next AN0 slot shows 0000000.
- Invalid BCD: digit1=4'hC. Required: AN1 low with C*=1111111.
- Blink: blink_en=1, blink_mask=0010, digits 1,2,3,4. Required: AN1 never goes low during 64-cycle phase=1 windows; AN1 is low in its slots during phase=0 windows. AN0, AN2 and AN3 are unaffected.
- Async reset mid-operation: assert rst for 1 cycle during the AN2 slot. Required: all AN and C* go to 1 in the same cycle without waiting for a clock edge. After release, AN0 is the first active anode and shows the current digit0.
- Long run with digits 9,0,5,7 held: over 1000 cycles, each AN is low exactly 25% of cycles (±1 slot) and C* matches decode(digit) for the active anode every cycle after the first.
